// File: rtl/writeback_regfile.sv
// Write-back stage and architectural integer register file.
// This block selects the write-back value from the MEM/WB bundle and commits it
// to x1..x31. It also serves two combinational decode read ports with a
// write-first bypass, exports the write-back value for EX forwarding, and keeps
// a count of retired instructions.
module writeback_regfile #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       wb_rd,
  input  logic [SIZE-1:0]  wb_imm,
  input  logic [SIZE-1:0]  wb_alu,
  input  logic [SIZE-1:0]  wb_pcplus4,
  input  logic [SIZE-1:0]  wb_mem,
  input  logic             wb_regwrite,
  input  logic [1:0]       wb_src,
  input  logic             wb_valid,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [SIZE-1:0]  rs1_data,
  output logic [SIZE-1:0]  rs2_data,
  output logic [SIZE-1:0]  fwd_data,
  output logic             fwd_en,
  output logic [4:0]       fwd_rd,
  output logic [CNT_W-1:0] instret
);

  localparam int NREGS = 32;

  // Write-back source encodings.
  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;
  localparam logic [1:0] SRC_IMM = 2'b11;

  logic [SIZE-1:0]  wb_value;
  logic             wr_active;
  logic [NREGS-1:0] wr_sel;
  logic [SIZE-1:0]  regs_reg [NREGS];
  logic [CNT_W-1:0] instret_reg;
  logic [CNT_W-1:0] instret_next;

  // Select the write-back value. All four encodings are legal, so there is no
  // don't-care case.
  always_comb begin
    wb_value = wb_alu;
    case (wb_src)
      SRC_ALU: wb_value = wb_alu;
      SRC_MEM: wb_value = wb_mem;
      SRC_PC4: wb_value = wb_pcplus4;
      SRC_IMM: wb_value = wb_imm;
      default: wb_value = wb_alu;
    endcase
  end

  // A write is real only when it targets a register other than x0. wb_valid
  // deliberately does not gate the write, because bubbles already arrive with
  // regwrite cleared.
  assign wr_active = wb_regwrite && (wb_rd != 5'd0);

  assign fwd_data = wb_value;
  assign fwd_en   = wr_active;
  assign fwd_rd   = wb_rd;

  // Decode the destination into one-hot per-register write strobes. Entry 0 is
  // tied low, so x0 can never be written.
  assign wr_sel[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_active && (wb_rd == 5'(gi));
    end
  endgenerate

  // Register storage. Reset clears every entry and takes priority over a write
  // presented in the same cycle. Entry 0 stays at zero permanently.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst) begin
        regs_reg[i] <= '0;
      end else if (wr_sel[i]) begin
        regs_reg[i] <= wb_value;
      end
    end
  end

  // Read port 1. x0 reads as zero. A write to the same register in the current
  // cycle is bypassed, so decode sees the new value (write-first behaviour).
  always_comb begin
    rs1_data = regs_reg[rs1_addr];
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (wr_active && (wb_rd == rs1_addr)) begin
      rs1_data = wb_value;
    end
  end

  // Read port 2. It follows the same rules as port 1 and is fully independent
  // of it.
  always_comb begin
    rs2_data = regs_reg[rs2_addr];
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (wr_active && (wb_rd == rs2_addr)) begin
      rs2_data = wb_value;
    end
  end

  // Next count. Every valid instruction in WB retires, including stores and
  // branches. The counter wraps naturally at the top of its range.
  always_comb begin
    instret_next = instret_reg;
    if (wb_valid) begin
      instret_next = instret_reg + CNT_W'(1);
    end
  end

  // Retired-instruction counter register. Reset has priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_reg <= '0;
    end else begin
      instret_reg <= instret_next;
    end
  end

  assign instret = instret_reg;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed and randomized checks for writeback_regfile.
// A second, narrow-counter instance shares the stimulus so that the counter
// wrap can be reached in a few cycles.
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_rd;
  logic [31:0] wb_imm, wb_alu, wb_pcplus4, wb_mem;
  logic        wb_regwrite;
  logic [1:0]  wb_src;
  logic        wb_valid;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, fwd_data;
  logic        fwd_en;
  logic [4:0]  fwd_rd;
  logic [63:0] instret;

  logic [31:0] s_rs1_data, s_rs2_data, s_fwd_data;
  logic        s_fwd_en;
  logic [4:0]  s_fwd_rd;
  logic [3:0]  s_instret;

  int errors = 0;
  int checks = 0;

  // Reference state used by the random test.
  logic [31:0] m_regs [32];
  logic [63:0] m_instret;

  writeback_regfile #(.SIZE(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .wb_rd(wb_rd), .wb_imm(wb_imm), .wb_alu(wb_alu),
    .wb_pcplus4(wb_pcplus4), .wb_mem(wb_mem), .wb_regwrite(wb_regwrite),
    .wb_src(wb_src), .wb_valid(wb_valid), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_data(fwd_data), .fwd_en(fwd_en),
    .fwd_rd(fwd_rd), .instret(instret)
  );

  writeback_regfile #(.SIZE(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .wb_rd(wb_rd), .wb_imm(wb_imm), .wb_alu(wb_alu),
    .wb_pcplus4(wb_pcplus4), .wb_mem(wb_mem), .wb_regwrite(wb_regwrite),
    .wb_src(wb_src), .wb_valid(wb_valid), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(s_rs1_data), .rs2_data(s_rs2_data), .fwd_data(s_fwd_data), .fwd_en(s_fwd_en),
    .fwd_rd(s_fwd_rd), .instret(s_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog that guarantees the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion before limit");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and leave the inputs stable for 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_rd = 0; wb_imm = 0; wb_alu = 0; wb_pcplus4 = 0; wb_mem = 0;
    wb_regwrite = 0; wb_src = 0; wb_valid = 0; rs1_addr = 0; rs2_addr = 0;
  endtask

  task automatic do_write(input logic [4:0] rd, input logic [31:0] val);
    wb_rd = rd; wb_alu = val; wb_src = 2'b00; wb_regwrite = 1; wb_valid = 1;
    step();
    wb_regwrite = 0; wb_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; wb_regwrite = 1; wb_valid = 1; wb_rd = 5; wb_alu = 32'hDEADBEEF;
    step(); step();
    rst = 0; idle_inputs(); rs1_addr = 5;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin errors++; $display("FAIL reset_x5: got %h want %h", rs1_data, 32'h0); end
    checks++;
    if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d want 0", instret); end
    checks++;
    if (fwd_en !== 1'b0 || fwd_data !== 32'h0) begin errors++; $display("FAIL reset_fwd: got en=%b data=%h want en=0 data=0", fwd_en, fwd_data); end
    $display("reset: rs1(x5)=%h instret=%0d", rs1_data, instret);
  endtask

  task automatic test_src_mux();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33; exp_v[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      wb_alu = 32'h11; wb_mem = 32'h22; wb_pcplus4 = 32'h33; wb_imm = 32'h44;
      wb_src = 2'(i); wb_rd = 5'(i + 1); wb_regwrite = 1; wb_valid = 1;
      #1;
      checks++;
      if (fwd_data !== exp_v[i]) begin errors++; $display("FAIL src_fwd%0d: got %h want %h", i, fwd_data, exp_v[i]); end
      checks++;
      if (fwd_en !== 1'b1 || fwd_rd !== 5'(i + 1)) begin errors++; $display("FAIL src_fwd_en%0d: got en=%b rd=%0d want en=1 rd=%0d", i, fwd_en, fwd_rd, i + 1); end
      step();
      $display("src: write x%0d src=%0d value=%h", i + 1, i, fwd_data);
    end
    idle_inputs();
    wb_alu = 32'h99; wb_mem = 32'h99; wb_pcplus4 = 32'h99; wb_imm = 32'h99;
    for (int i = 0; i < 4; i++) begin
      rs1_addr = 5'(i + 1); rs2_addr = 5'(i + 1);
      #1;
      checks++;
      if (rs1_data !== exp_v[i] || rs2_data !== exp_v[i]) begin
        errors++; $display("FAIL src_read_x%0d: got rs1=%h rs2=%h want %h", i + 1, rs1_data, rs2_data, exp_v[i]);
      end
      $display("src: read x%0d = %h", i + 1, rs1_data);
    end
  endtask

  task automatic test_x0();
    idle_inputs();
    wb_rd = 0; wb_alu = 32'hFFFFFFFF; wb_src = 0; wb_regwrite = 1; wb_valid = 1; rs1_addr = 0; rs2_addr = 0;
    #1;
    checks++;
    if (fwd_en !== 1'b0) begin errors++; $display("FAIL x0_fwd_en: got %b want 0", fwd_en); end
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin errors++; $display("FAIL x0_same: got rs1=%h rs2=%h want 0", rs1_data, rs2_data); end
    step();
    wb_regwrite = 0; wb_valid = 0;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_next: got %h want 0", rs1_data); end
    $display("x0: write dropped, rs1(x0)=%h", rs1_data);
  endtask

  task automatic test_bypass();
    idle_inputs();
    do_write(7, 32'h5);
    // Write of 0xA to x7 with both ports on x7.
    wb_rd = 7; wb_alu = 32'hA; wb_src = 0; wb_regwrite = 1; wb_valid = 1; rs1_addr = 7; rs2_addr = 7;
    #1;
    checks++;
    if (rs1_data !== 32'hA || rs2_data !== 32'hA) begin errors++; $display("FAIL bypass_hit: got rs1=%h rs2=%h want a", rs1_data, rs2_data); end
    // Same stimulus, different read register on port 2 sees the old value.
    rs2_addr = 1;
    #1;
    checks++;
    if (rs2_data !== 32'h11) begin errors++; $display("FAIL bypass_other: got %h want 11", rs2_data); end
    // Same stimulus with regwrite off: no bypass.
    rs2_addr = 7; wb_regwrite = 0;
    #1;
    checks++;
    if (rs1_data !== 32'h5 || rs2_data !== 32'h5) begin errors++; $display("FAIL bypass_off: got rs1=%h rs2=%h want 5", rs1_data, rs2_data); end
    step();
    #1;
    checks++;
    if (rs1_data !== 32'h5) begin errors++; $display("FAIL bypass_nowrite: got %h want 5", rs1_data); end
    $display("bypass: x7 reads %h", rs1_data);
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    rst = 1; wb_rd = 3; wb_alu = 32'h1234; wb_regwrite = 1; wb_valid = 1;
    step();
    rst = 0; idle_inputs(); rs1_addr = 3; rs2_addr = 7;
    #1;
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin errors++; $display("FAIL reset_mid: got rs1=%h rs2=%h want 0", rs1_data, rs2_data); end
    checks++;
    if (instret !== 64'd0) begin errors++; $display("FAIL reset_mid_instret: got %0d want 0", instret); end
    $display("reset_mid: x3=%h x7=%h", rs1_data, rs2_data);
  endtask

  task automatic test_instret();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      wb_valid = 1; wb_rd = 5'(10 + i); wb_alu = 32'(i);
      wb_regwrite = (i == 2 || i == 5 || i == 8) ? 1'b0 : 1'b1;
      step();
    end
    checks++;
    if (instret !== 64'd10) begin errors++; $display("FAIL instret_10: got %0d want 10", instret); end
    $display("instret: after 10 valid = %0d", instret);
    // A non-valid cycle does not count even with regwrite set.
    wb_valid = 0; wb_regwrite = 1; wb_rd = 20;
    step();
    checks++;
    if (instret !== 64'd10) begin errors++; $display("FAIL instret_bubble: got %0d want 10", instret); end
    wb_regwrite = 0;
    for (int i = 0; i < 5; i++) begin wb_valid = 1; step(); end
    checks++;
    if (s_instret !== 4'd15) begin errors++; $display("FAIL instret_max: got %0d want 15", s_instret); end
    step();
    checks++;
    if (s_instret !== 4'd0) begin errors++; $display("FAIL instret_wrap: got %0d want 0", s_instret); end
    checks++;
    if (instret !== 64'd16) begin errors++; $display("FAIL instret_16: got %0d want 16", instret); end
    $display("instret: wide=%0d narrow=%0d", instret, s_instret);
    idle_inputs();
  endtask

  function automatic logic [31:0] sel_value();
    case (wb_src)
      2'b00: return wb_alu;
      2'b01: return wb_mem;
      2'b10: return wb_pcplus4;
      default: return wb_imm;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_regwrite && wb_rd != 0 && wb_rd == a) return sel_value();
    return m_regs[a];
  endfunction

  task automatic test_random();
    int loc_err;
    loc_err = 0;
    idle_inputs();
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_instret = 64'd0;
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      wb_valid = $urandom_range(0, 3) != 0;
      wb_regwrite = wb_valid && ($urandom_range(0, 3) != 0);
      wb_rd = 5'($urandom_range(0, 31));
      wb_src = 2'($urandom_range(0, 3));
      wb_alu = $urandom; wb_mem = $urandom; wb_pcplus4 = $urandom; wb_imm = $urandom;
      rs1_addr = ($urandom_range(0, 3) == 0) ? wb_rd : 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (rs1_data !== exp_read(rs1_addr) || rs2_data !== exp_read(rs2_addr)) begin
        errors++; loc_err++;
        if (loc_err < 10) $display("FAIL rand_read cycle %0d: got rs1=%h rs2=%h want %h %h", c, rs1_data, rs2_data, exp_read(rs1_addr), exp_read(rs2_addr));
      end
      checks++;
      if (fwd_data !== sel_value() || fwd_en !== (wb_regwrite && wb_rd != 0) || fwd_rd !== wb_rd) begin
        errors++; loc_err++;
        if (loc_err < 10) $display("FAIL rand_fwd cycle %0d: got data=%h en=%b rd=%0d want data=%h", c, fwd_data, fwd_en, fwd_rd, sel_value());
      end
      // Update the reference at the edge using the inputs presented this cycle.
      if (rst) begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_instret = 64'd0;
      end else begin
        if (wb_regwrite && wb_rd != 0) m_regs[wb_rd] = sel_value();
        if (wb_valid) m_instret = m_instret + 64'd1;
      end
      step();
      checks++;
      if (instret !== m_instret) begin
        errors++; loc_err++;
        if (loc_err < 10) $display("FAIL rand_instret cycle %0d: got %0d want %0d", c, instret, m_instret);
      end
    end
    rst = 0;
    idle_inputs();
    $display("random: 10000 cycles, %0d discrepancies", loc_err);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_src_mux();
    test_x0();
    test_bypass();
    test_reset_mid();
    test_instret();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
